// File: rtl/rr_grant_collector_if.sv
// Bundle of grant/data inputs, acknowledges and the output FIFO stream
// between the arbiter side, the collector and the downstream consumer.
interface rr_grant_collector_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [3:0]        gnt;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] din1;
    logic [DATA_W-1:0] din2;
    logic [DATA_W-1:0] din3;
    logic [3:0]        ack;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_src;
    logic [CNT_W-1:0]  count;
    logic              gnt_err;

    // Environment side: drives grants, data and downstream ready
    modport master (
        output gnt, din0, din1, din2, din3, out_ready,
        input  ack, out_valid, out_data, out_src, count, gnt_err
    );

    // Collector side
    modport slave (
        input  gnt, din0, din1, din2, din3, out_ready,
        output ack, out_valid, out_data, out_src, count, gnt_err
    );
endinterface

// File: rtl/rr_grant_collector.sv
// Captures the granted requester's word into a small FIFO tagged with its
// source index, acknowledges the capture, and streams entries downstream.
module rr_grant_collector #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input logic              clk,
    input logic              rst_n,
    rr_grant_collector_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              gnt_err_q;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [1:0]        mem_src  [DEPTH];

    logic              gnt_legal;
    logic              multi_hot;
    logic [1:0]        idx;
    logic [DATA_W-1:0] din_sel;
    logic              full;
    logic              push;
    logic              pop;
    logic              not_empty;

    // A legal grant has exactly one bit set; any other non-zero value is an error
    assign gnt_legal = (bus.gnt != 4'b0000) && ((bus.gnt & 4'(bus.gnt - 4'd1)) == 4'b0000);
    assign multi_hot = (bus.gnt != 4'b0000) && !gnt_legal;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign not_empty = (count_q != '0);

    // Full blocks the push even when a pop frees a slot this cycle, so ack never depends on out_ready
    assign push = gnt_legal && !full;
    assign pop  = not_empty && bus.out_ready;

    // Encode the one-hot grant into a requester index
    always_comb begin
        idx = 2'd0;
        case (bus.gnt)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // Select the granted requester's data word
    always_comb begin
        din_sel = bus.din0;
        case (idx)
            2'd1:    din_sel = bus.din1;
            2'd2:    din_sel = bus.din2;
            2'd3:    din_sel = bus.din3;
            default: din_sel = bus.din0;
        endcase
    end

    // Write the captured word and its tag at the tail; storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= din_sel;
            mem_src[wr_ptr]  <= idx;
        end
    end

    // Pointers, occupancy and the error pulse; reset discards all queued entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            gnt_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            gnt_err_q <= multi_hot;
        end
    end

    assign bus.ack       = bus.gnt & {4{push}};
    assign bus.out_valid = not_empty;
    assign bus.out_data  = mem_data[rd_ptr];
    assign bus.out_src   = mem_src[rd_ptr];
    assign bus.count     = count_q;
    assign bus.gnt_err   = gnt_err_q;

endmodule

// File: tb/tb_rr_grant_collector.sv
// Directed bench for rr_grant_collector: table of per-cycle vectors plus
// hand-written sequences for full/pop, wrap-around and mid-run reset.
module tb_rr_grant_collector;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rr_grant_collector_if #(.DATA_W(8), .DEPTH(4)) bus ();

    rr_grant_collector #(.DATA_W(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] dat;
        logic       rdy;
        logic [3:0] ack;
        logic [2:0] cnt;
        logic       hd;
        logic [7:0] hdat;
        logic [1:0] hsrc;
        logic       err;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, check ack before the edge, check state after it
    task automatic step(input string nm, input logic [3:0] g, input logic [7:0] d, input logic r,
                        input logic [3:0] eack, input logic [2:0] ecnt, input logic hd,
                        input logic [7:0] edat, input logic [1:0] esrc, input logic eerr);
        @(negedge clk);
        bus.gnt       = g;
        bus.din0      = (g == 4'b0001) ? d : 8'hEE;
        bus.din1      = (g == 4'b0010) ? d : 8'hEE;
        bus.din2      = (g == 4'b0100) ? d : 8'hEE;
        bus.din3      = (g == 4'b1000) ? d : 8'hEE;
        bus.out_ready = r;
        #1;
        chk({nm, " ack"}, 32'(bus.ack), 32'(eack));
        @(posedge clk);
        #1;
        chk({nm, " count"}, 32'(bus.count), 32'(ecnt));
        chk({nm, " out_valid"}, 32'(bus.out_valid), 32'(ecnt != 3'd0));
        chk({nm, " gnt_err"}, 32'(bus.gnt_err), 32'(eerr));
        if (hd) begin
            chk({nm, " out_data"}, 32'(bus.out_data), 32'(edat));
            chk({nm, " out_src"}, 32'(bus.out_src), 32'(esrc));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;

        //              gnt      dat    rdy  ack      cnt  hd  hdat   hsrc err
        vecs[0]  = '{4'b0010, 8'hA5, 1'b1, 4'b0010, 3'd1, 1, 8'hA5, 2'd1, 0};
        vecs[1]  = '{4'b0000, 8'h00, 1'b1, 4'b0000, 3'd0, 0, 8'h00, 2'd0, 0};
        vecs[2]  = '{4'b0001, 8'h11, 1'b0, 4'b0001, 3'd1, 1, 8'h11, 2'd0, 0};
        vecs[3]  = '{4'b0010, 8'h22, 1'b0, 4'b0010, 3'd2, 1, 8'h11, 2'd0, 0};
        vecs[4]  = '{4'b0100, 8'h33, 1'b0, 4'b0100, 3'd3, 1, 8'h11, 2'd0, 0};
        vecs[5]  = '{4'b1000, 8'h44, 1'b0, 4'b1000, 3'd4, 1, 8'h11, 2'd0, 0};
        vecs[6]  = '{4'b0001, 8'h55, 1'b0, 4'b0000, 3'd4, 1, 8'h11, 2'd0, 0};
        vecs[7]  = '{4'b0000, 8'h00, 1'b1, 4'b0000, 3'd3, 1, 8'h22, 2'd1, 0};
        vecs[8]  = '{4'b0000, 8'h00, 1'b1, 4'b0000, 3'd2, 1, 8'h33, 2'd2, 0};
        vecs[9]  = '{4'b0000, 8'h00, 1'b1, 4'b0000, 3'd1, 1, 8'h44, 2'd3, 0};
        vecs[10] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 3'd0, 0, 8'h00, 2'd0, 0};
        vecs[11] = '{4'b0110, 8'h66, 1'b1, 4'b0000, 3'd0, 0, 8'h00, 2'd0, 1};
        vecs[12] = '{4'b0100, 8'h77, 1'b0, 4'b0100, 3'd1, 1, 8'h77, 2'd2, 0};
        vecs[13] = '{4'b1010, 8'h88, 1'b0, 4'b0000, 3'd1, 1, 8'h77, 2'd2, 1};
        vecs[14] = '{4'b1100, 8'h99, 1'b0, 4'b0000, 3'd1, 1, 8'h77, 2'd2, 1};
        vecs[15] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 3'd0, 0, 8'h00, 2'd0, 0};
        vecs[16] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 3'd0, 0, 8'h00, 2'd0, 0};
        vecs[17] = '{4'b0001, 8'h9A, 1'b1, 4'b0001, 3'd1, 1, 8'h9A, 2'd0, 0};
        vecs[18] = '{4'b1000, 8'hBC, 1'b1, 4'b1000, 3'd1, 1, 8'hBC, 2'd3, 0};
        vecs[19] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 3'd0, 0, 8'h00, 2'd0, 0};

        rst_n         = 1'b0;
        bus.gnt       = 4'b0000;
        bus.din0      = 8'h00;
        bus.din1      = 8'h00;
        bus.din2      = 8'h00;
        bus.din3      = 8'h00;
        bus.out_ready = 1'b0;
        #2;
        chk("reset count", 32'(bus.count), 32'd0);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset gnt_err", 32'(bus.gnt_err), 32'd0);
        chk("reset ack", 32'(bus.ack), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].dat, vecs[i].rdy, vecs[i].ack,
                 vecs[i].cnt, vecs[i].hd, vecs[i].hdat, vecs[i].hsrc, vecs[i].err);
        end

        // Full with a pop in the same cycle: push blocked, then accepted next cycle
        step("full f0", 4'b0001, 8'h01, 1'b0, 4'b0001, 3'd1, 1, 8'h01, 2'd0, 0);
        step("full f1", 4'b0010, 8'h02, 1'b0, 4'b0010, 3'd2, 1, 8'h01, 2'd0, 0);
        step("full f2", 4'b0100, 8'h03, 1'b0, 4'b0100, 3'd3, 1, 8'h01, 2'd0, 0);
        step("full f3", 4'b1000, 8'h04, 1'b0, 4'b1000, 3'd4, 1, 8'h01, 2'd0, 0);
        step("full popblk", 4'b0100, 8'hC3, 1'b1, 4'b0000, 3'd3, 1, 8'h02, 2'd1, 0);
        step("full held", 4'b0100, 8'hC3, 1'b1, 4'b0100, 3'd3, 1, 8'h03, 2'd2, 0);
        step("full d0", 4'b0000, 8'h00, 1'b1, 4'b0000, 3'd2, 1, 8'h04, 2'd3, 0);
        step("full d1", 4'b0000, 8'h00, 1'b1, 4'b0000, 3'd1, 1, 8'hC3, 2'd2, 0);
        step("full d2", 4'b0000, 8'h00, 1'b1, 4'b0000, 3'd0, 0, 8'h00, 2'd0, 0);

        // Wrap-around streaming: every grant accepted, occupancy stays at one
        for (int i = 0; i < 12; i++) begin
            logic [3:0] g;
            g = 4'b0001 << (i % 4);
            step($sformatf("wrap%0d", i), g, 8'(8'h30 + i), 1'b1, g, 3'd1, 1,
                 8'(8'h30 + i), 2'(i % 4), 0);
        end
        step("wrap drain", 4'b0000, 8'h00, 1'b1, 4'b0000, 3'd0, 0, 8'h00, 2'd0, 0);

        // Reset mid-operation discards queued entries immediately
        step("rst f0", 4'b0001, 8'hA1, 1'b0, 4'b0001, 3'd1, 1, 8'hA1, 2'd0, 0);
        step("rst f1", 4'b0010, 8'hA2, 1'b0, 4'b0010, 3'd2, 1, 8'hA1, 2'd0, 0);
        step("rst f2", 4'b0100, 8'hA3, 1'b0, 4'b0100, 3'd3, 1, 8'hA1, 2'd0, 0);
        bus.gnt = 4'b0000;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst count", 32'(bus.count), 32'd0);
        chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst ack", 32'(bus.ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post rst", 4'b1000, 8'h5D, 1'b0, 4'b1000, 3'd1, 1, 8'h5D, 2'd3, 0);
        step("post pop", 4'b0000, 8'h00, 1'b1, 4'b0000, 3'd0, 0, 8'h00, 2'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
